// File: rtl/sram_port_arbiter.sv
// Merges the instruction-fetch and load/store request ports onto one synchronous single-port SRAM.
// Data requests win, except that a fetch waiting behind STARVE_LIMIT consecutive data grants gets the next contested cycle.
module sram_port_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int ADDR_W       = 32
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    output logic [31:0]       inst_rdata,

    input  logic              data_req,
    input  logic              data_wr,
    input  logic [3:0]        data_wstrb,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [31:0]       data_wdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic [31:0]       data_rdata,

    output logic              mem_en,
    output logic [3:0]        mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam int STREAK_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_INST = 2'd1,
        OWN_DATA = 2'd2
    } owner_e;

    owner_e              resp_owner_q, resp_owner_d;
    logic                resp_load_q, resp_load_d;
    logic [STREAK_W-1:0] streak_q, streak_d;
    logic [31:0]         inst_hold_q, inst_hold_d;
    logic [31:0]         data_hold_q, data_hold_d;

    logic force_inst;
    logic grant_data;
    logic grant_inst;
    logic data_load_rsp;

    // Grants are forced low during reset so nothing is accepted while the pipeline is clearing.
    always_comb begin
        force_inst = inst_req & data_req & (streak_q == STREAK_MAX);
        grant_data = ~reset & data_req & ~force_inst;
        grant_inst = ~reset & inst_req & ~grant_data;
    end

    assign inst_addr_ok = grant_inst;
    assign data_addr_ok = grant_data;

    assign mem_en    = grant_data | grant_inst;
    assign mem_we    = (grant_data & data_wr) ? data_wstrb : 4'b0000;
    assign mem_addr  = grant_data ? data_addr : inst_addr;
    assign mem_wdata = data_wdata;

    assign inst_data_ok  = (resp_owner_q == OWN_INST);
    assign data_data_ok  = (resp_owner_q == OWN_DATA);
    assign data_load_rsp = data_data_ok & resp_load_q;

    assign inst_rdata = inst_data_ok  ? mem_rdata : inst_hold_q;
    assign data_rdata = data_load_rsp ? mem_rdata : data_hold_q;

    // NOTE: every variable gets its default first, so no path through this block can infer a latch.
    always_comb begin
        resp_owner_d = OWN_NONE;
        resp_load_d  = 1'b0;
        streak_d     = streak_q;
        inst_hold_d  = inst_hold_q;
        data_hold_d  = data_hold_q;

        if (grant_data) begin
            resp_owner_d = OWN_DATA;
            resp_load_d  = ~data_wr;
        end else if (grant_inst) begin
            resp_owner_d = OWN_INST;
        end

        // Streak counts data grants that a waiting fetch lost; any fetch grant or idle fetch port clears it.
        if (grant_inst || !inst_req) begin
            streak_d = '0;
        end else if (grant_data && streak_q != STREAK_MAX) begin
            streak_d = streak_q + 1'b1;
        end

        if (inst_data_ok) begin
            inst_hold_d = mem_rdata;
        end
        if (data_load_rsp) begin
            data_hold_d = mem_rdata;
        end
    end

    // NOTE: state uses non-blocking assignments and clears asynchronously, dropping any pending response at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            resp_owner_q <= OWN_NONE;
            resp_load_q  <= 1'b0;
            streak_q     <= '0;
            inst_hold_q  <= '0;
            data_hold_q  <= '0;
        end else begin
            resp_owner_q <= resp_owner_d;
            resp_load_q  <= resp_load_d;
            streak_q     <= streak_d;
            inst_hold_q  <= inst_hold_d;
            data_hold_q  <= data_hold_d;
        end
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Randomised and directed bench for sram_port_arbiter: a driver predicts grants and queues expected
// responses from a word-level memory model; a separate monitor pops and compares every response cycle.
`timescale 1ns/1ps
module tb_sram_port_arbiter;

    localparam int LIMIT = 4;
    localparam int AW    = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          inst_req;
    logic [AW-1:0] inst_addr;
    logic          inst_addr_ok;
    logic          inst_data_ok;
    logic [31:0]   inst_rdata;
    logic          data_req;
    logic          data_wr;
    logic [3:0]    data_wstrb;
    logic [AW-1:0] data_addr;
    logic [31:0]   data_wdata;
    logic          data_addr_ok;
    logic          data_data_ok;
    logic [31:0]   data_rdata;
    logic          mem_en;
    logic [3:0]    mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata = '0;

    always #5 clk = ~clk;

    sram_port_arbiter #(.STARVE_LIMIT(LIMIT), .ADDR_W(AW)) dut (
        .clk          (clk),
        .reset        (reset),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_wstrb   (data_wstrb),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .mem_en       (mem_en),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    typedef struct {
        bit          is_inst;
        bit          is_load;
        logic [31:0] data;
    } resp_t;

    resp_t       exp_q[$];
    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_inst_hold = '0;
    logic [31:0] exp_data_hold = '0;
    int          ref_streak = 0;
    logic [31:0] ref_mem [logic [29:0]];

    bit          ip_v = 0;
    logic [31:0] ip_addr = '0;
    bit          dp_v = 0;
    bit          dp_wr = 0;
    logic [3:0]  dp_strb = '0;
    logic [31:0] dp_addr = '0;
    logic [31:0] dp_wdata = '0;
    bit          rst_drive = 1;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory image: fold upper address bits onto a 1K-word SRAM; two words carry the directed-test contents.
    function automatic logic [9:0] idx_of(logic [31:0] a);
        return a[11:2] ^ a[29:20];
    endfunction

    function automatic logic [31:0] image_of(logic [9:0] i);
        if (i == 10'h1C0) return 32'h0280_0404;
        if (i == 10'h040) return 32'h1122_3344;
        return {6'h2A, i, 6'h15, ~i};
    endfunction

    function automatic logic [31:0] merge(logic [31:0] old_w, logic [31:0] new_w, logic [3:0] strb);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = new_w[8*b +: 8];
        return r;
    endfunction

    // SRAM environment: synchronous, read data valid the cycle after enable.
    logic [31:0] sram_mem [1024];
    bit          sram_written [1024];

    function automatic logic [31:0] sram_word(logic [31:0] a);
        return sram_written[idx_of(a)] ? sram_mem[idx_of(a)] : image_of(idx_of(a));
    endfunction

    always @(posedge clk) begin
        if (mem_en) begin
            mem_rdata <= merge(sram_word(mem_addr), mem_wdata, mem_we);
            if (mem_we != 4'b0000) begin
                sram_mem[idx_of(mem_addr)]     <= merge(sram_word(mem_addr), mem_wdata, mem_we);
                sram_written[idx_of(mem_addr)] <= 1'b1;
            end
        end
    end

    function automatic logic [31:0] ref_read(logic [31:0] a);
        return ref_mem.exists(a[31:2]) ? ref_mem[a[31:2]] : image_of(idx_of(a));
    endfunction

    // One cycle: present the pending master requests, predict the grant, queue the expected response.
    task automatic drive_cycle();
        bit    gd;
        bit    gi;
        resp_t r;
        @(negedge clk);
        reset      = rst_drive;
        inst_req   = ip_v;
        inst_addr  = ip_addr;
        data_req   = dp_v;
        data_wr    = dp_wr;
        data_wstrb = dp_strb;
        data_addr  = dp_addr;
        data_wdata = dp_wdata;
        #1;
        gd = !reset && dp_v && !(ip_v && ref_streak == LIMIT);
        gi = !reset && ip_v && !gd;
        check("inst_addr_ok", inst_addr_ok, gi);
        check("data_addr_ok", data_addr_ok, gd);
        check("mem_en", mem_en, gd || gi);
        check("mem_we", mem_we, (gd && dp_wr) ? dp_strb : 4'b0000);
        if (gd) begin
            check("mem_addr_data", mem_addr, dp_addr);
            if (dp_wr) check("mem_wdata", mem_wdata, dp_wdata);
            r.is_inst = 0;
            r.is_load = !dp_wr;
            r.data    = ref_read(dp_addr);
            if (dp_wr) ref_mem[dp_addr[31:2]] = merge(r.data, dp_wdata, dp_strb);
            exp_q.push_back(r);
            dp_v = 0;
        end else if (gi) begin
            check("mem_addr_inst", mem_addr, ip_addr);
            r.is_inst = 1;
            r.is_load = 1;
            r.data    = ref_read(ip_addr);
            exp_q.push_back(r);
            ip_v = 0;
        end
        // Streak: data wins over a waiting fetch in a row, saturating at LIMIT.
        if (reset || gi || !ip_v) ref_streak = 0;
        else if (gd) ref_streak = (ref_streak < LIMIT) ? ref_streak + 1 : LIMIT;
    endtask

    task automatic idle(int n);
        ip_v = 0;
        dp_v = 0;
        repeat (n) drive_cycle();
    endtask

    task automatic new_inst(logic [31:0] a);
        ip_v = 1;
        ip_addr = a;
    endtask

    task automatic new_data(bit wr, logic [3:0] strb, logic [31:0] a, logic [31:0] wd);
        dp_v = 1;
        dp_wr = wr;
        dp_strb = strb;
        dp_addr = a;
        dp_wdata = wd;
    endtask

    function automatic logic [31:0] rand_addr();
        return 32'h200 + {$urandom_range(0, 31), 2'b00};
    endfunction

    task automatic async_reset(int cycles);
        @(posedge clk);
        #1;
        reset = 1;
        rst_drive = 1;
        exp_q.delete();
        exp_inst_hold = '0;
        exp_data_hold = '0;
        ref_streak = 0;
        repeat (cycles) drive_cycle();
        rst_drive = 0;
    endtask

    // Monitor: one response per cycle, exactly one cycle after its grant.
    initial begin
        resp_t e;
        bit    have;
        forever begin
            @(posedge clk);
            #2;
            if (reset) begin
                check("rst_inst_data_ok", inst_data_ok, 0);
                check("rst_data_data_ok", data_data_ok, 0);
                check("rst_inst_rdata", inst_rdata, 0);
                check("rst_data_rdata", data_rdata, 0);
            end else begin
                have = exp_q.size() > 0;
                if (have) e = exp_q.pop_front();
                check("inst_data_ok", inst_data_ok, have && e.is_inst);
                check("data_data_ok", data_data_ok, have && !e.is_inst);
                if (have && e.is_inst) exp_inst_hold = e.data;
                if (have && !e.is_inst && e.is_load) exp_data_hold = e.data;
                check("inst_rdata", inst_rdata, exp_inst_hold);
                if (!(have && !e.is_inst && !e.is_load)) check("data_rdata", data_rdata, exp_data_hold);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1;
        inst_req = 0; inst_addr = '0;
        data_req = 0; data_wr = 0; data_wstrb = '0; data_addr = '0; data_wdata = '0;

        rst_drive = 1;
        idle(3);
        rst_drive = 0;
        idle(2);

        // Single fetch, then its data must stay on inst_rdata.
        new_inst(32'h1C00_0000);
        drive_cycle();
        idle(3);
        check("fetch_hold", inst_rdata, 32'h0280_0404);

        // Partial store followed immediately by a load of the same word.
        new_data(1, 4'b0011, 32'h100, 32'hAABB_CCDD);
        drive_cycle();
        new_data(0, 4'b0000, 32'h100, 32'h0);
        drive_cycle();
        idle(3);
        check("store_load_hold", data_rdata, 32'h1122_CCDD);

        // Both masters always requesting: data wins LIMIT times, then fetch gets one.
        for (int k = 0; k < 20; k++) begin
            if (!ip_v) new_inst(rand_addr());
            if (!dp_v) new_data(0, 4'b0000, rand_addr(), 32'h0);
            drive_cycle();
            check("contention_pattern", inst_addr_ok, (k % 5) == 4);
        end
        idle(2);

        // Data-only stream, then a lone fetch is granted at once.
        for (int k = 0; k < 6; k++) begin
            new_data($urandom_range(0, 1), 4'($urandom), rand_addr(), $urandom);
            drive_cycle();
        end
        new_inst(32'h0000_0040);
        drive_cycle();
        check("lone_fetch_grant", inst_addr_ok, 1);
        idle(2);

        // Reset right after a grant: the pending response must vanish.
        new_data(0, 4'b0000, 32'h100, 32'h0);
        drive_cycle();
        new_inst(32'h0000_0010);
        new_data(1, 4'b1111, 32'h104, 32'h1234_5678);
        async_reset(3);
        idle(1);
        new_inst(32'h1C00_0000);
        drive_cycle();
        idle(2);
        check("post_reset_fetch", inst_rdata, 32'h0280_0404);

        // Back-to-back fetches with no bubbles.
        for (int k = 0; k < 8; k++) begin
            new_inst(32'(k * 4));
            drive_cycle();
            check("burst_grant", inst_addr_ok, 1);
        end
        idle(2);

        // Random traffic.
        for (int k = 0; k < 400; k++) begin
            if (!ip_v && $urandom_range(0, 99) < 60) new_inst(rand_addr());
            if (!dp_v && $urandom_range(0, 99) < 60)
                new_data($urandom_range(0, 1), 4'($urandom), rand_addr(), $urandom);
            drive_cycle();
        end
        idle(3);

        @(posedge clk);
        #3;
        check("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
